// File: rtl/cnn_conv_mc.sv
`default_nettype none
// ============================================================================
// Module : cnn_conv_mc
// Multi-channel 3x3 valid-mode convolution: bias, optional ReLU, saturation.
// Rev    : 1.0
// ============================================================================
module cnn_conv_mc #(
    parameter int CH    = 3,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int DW    = 8,
    parameter int KW    = 8,
    parameter int OW    = 16,
    parameter int RELU  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_we,
    input  logic [$clog2(CH*9+1)-1:0] cfg_addr,
    input  logic [OW-1:0]             cfg_data,
    input  logic                      in_valid,
    input  logic [CH*DW-1:0]          in_pxl,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [OW-1:0]             out_pxl,
    output logic                      out_last,
    input  logic                      out_ready
);

    localparam int NK      = CH * 9;
    localparam int AW      = $clog2(NK + 1);
    localparam int CW      = $clog2(IMG_W);
    localparam int RW      = $clog2(IMG_H);
    localparam int PW      = DW + 1 + KW;
    localparam int ACC_REQ = DW + KW + 2 + $clog2(NK);
    localparam int ACCW    = (ACC_REQ > OW) ? ACC_REQ : OW + 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic                   w_en;
    logic                   w_take;
    logic [RW-1:0]          r_row;
    logic [CW-1:0]          r_col;
    logic signed [KW-1:0]   r_kern [NK];
    logic signed [OW-1:0]   r_bias;
    logic [DW-1:0]          r_lb0  [CH][IMG_W];
    logic [DW-1:0]          r_lb1  [CH][IMG_W];
    logic [DW-1:0]          r_win  [CH][3][2];
    logic [DW-1:0]          w_pix  [NK];
    logic signed [PW-1:0]   r_prod [NK];
    logic                   r_v1;
    logic                   r_last1;
    logic signed [ACCW-1:0] w_sum;
    logic signed [ACCW-1:0] w_clip;
    logic [OW-1:0]          w_res;

    assign w_en     = !(out_valid && !out_ready);
    assign in_ready = w_en;
    assign w_take   = in_valid && w_en;

    // Window seen by the incoming pixel: two stored columns plus the new column
    // assembled from both line buffers and the live input.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            for (int i = 0; i < 3; i++) begin
                w_pix[c*9 + i*3 + 0] = r_win[c][i][0];
                w_pix[c*9 + i*3 + 1] = r_win[c][i][1];
            end
            w_pix[c*9 + 2] = r_lb1[c][r_col];
            w_pix[c*9 + 5] = r_lb0[c][r_col];
            w_pix[c*9 + 8] = in_pxl[c*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (w_take) begin
            for (int c = 0; c < CH; c++) begin
                r_lb1[c][r_col] <= r_lb0[c][r_col];
                r_lb0[c][r_col] <= in_pxl[c*DW +: DW];
                for (int i = 0; i < 3; i++) begin
                    r_win[c][i][0] <= w_pix[c*9 + i*3 + 1];
                    r_win[c][i][1] <= w_pix[c*9 + i*3 + 2];
                end
            end
        end
        if (w_en) begin
            for (int k = 0; k < NK; k++) begin
                r_prod[k] <= PW'($signed({1'b0, w_pix[k]})) * PW'(r_kern[k]);
            end
        end
    end

    always_comb begin
        w_sum = ACCW'(r_bias);
        for (int k = 0; k < NK; k++) begin
            w_sum = w_sum + ACCW'(r_prod[k]);
        end
        w_clip = w_sum;
        if ((RELU != 0) && w_sum[ACCW-1]) begin
            w_clip = '0;
        end
        if (w_clip > SAT_MAX) begin
            w_res = SAT_MAX[OW-1:0];
        end else if (w_clip < SAT_MIN) begin
            w_res = SAT_MIN[OW-1:0];
        end else begin
            w_res = w_clip[OW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row     <= '0;
            r_col     <= '0;
            r_v1      <= 1'b0;
            r_last1   <= 1'b0;
            out_valid <= 1'b0;
            out_pxl   <= '0;
            out_last  <= 1'b0;
            r_bias    <= '0;
            for (int k = 0; k < NK; k++) begin
                r_kern[k] <= '0;
            end
        end else begin
            if (cfg_we) begin
                if (cfg_addr < AW'(NK)) begin
                    r_kern[cfg_addr] <= cfg_data[KW-1:0];
                end else if (cfg_addr == AW'(NK)) begin
                    r_bias <= cfg_data;
                end
            end
            if (w_take) begin
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (w_en) begin
                r_v1      <= w_take && (r_row >= RW'(2)) && (r_col >= CW'(2));
                r_last1   <= w_take && (r_row == ROW_LAST) && (r_col == COL_LAST);
                out_valid <= r_v1;
                out_last  <= r_v1 && r_last1;
                if (r_v1) begin
                    out_pxl <= w_res;
                end
            end
        end
    end

endmodule
`default_nettype wire
